// File: rtl/fop_pkg.sv
// Shared definitions for the LUT evaluator: loader state encoding and default truth table.
package fop_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } ld_state_t;

    // f(k)=1 for k in {0,1,2,3,5,7,8,11,13}
    localparam logic [15:0] FOP_INIT_4 = 16'h29AF;

endpackage

// File: rtl/fop_cfg_loader.sv
// Serial truth-table loader: shifts 2**N bits (MSB index first) into a shadow
// register and raises commit for one cycle once the last bit has arrived.
module fop_cfg_loader
    import fop_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    input  logic              cfg_bit,
    output logic [2**N-1:0]   shadow,
    output logic              commit
);

    localparam int unsigned TW = 2**N;

    ld_state_t       state;
    ld_state_t       state_nxt;
    logic [N-1:0]    cnt;
    logic [N-1:0]    cnt_nxt;
    logic [TW-1:0]   shadow_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shadow <= shadow_nxt;
        end
    end

    // The first bit is taken in IDLE, so SHIFT sees bits 2..2**N and commits when cnt wraps.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    shadow_nxt = {shadow[TW-2:0], cfg_bit};
                    cnt_nxt    = N'(1);
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                if (cfg_valid) begin
                    shadow_nxt = {shadow[TW-2:0], cfg_bit};
                    if (cnt == '1) begin
                        cnt_nxt   = '0;
                        state_nxt = COMMIT;
                    end else begin
                        cnt_nxt = cnt + N'(1);
                    end
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/fop_lut_eval.sv
// Registered N-input LUT evaluator with ready/valid handshake and serial table reload.
// Optional hit counter enabled by defining FOP_HIT_CNT_EN.
module fop_lut_eval
    import fop_pkg::*;
#(
    parameter int unsigned      N    = 4,
    parameter logic [2**N-1:0]  INIT = FOP_INIT_4,
    parameter int unsigned      CW   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out,
    input  logic           cfg_valid,
    input  logic           cfg_bit,
    output logic           cfg_done,
    output logic [CW-1:0]  hit_cnt
);

    logic [2**N-1:0] lut;
    logic [2**N-1:0] shadow;
    logic            commit;
    logic            accept;

    fop_cfg_loader #(
        .N(N)
    ) u_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .shadow    (shadow),
        .commit    (commit)
    );

    assign cfg_done = commit;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // An operand accepted during commit still reads the old table at this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut <= INIT;
        end else if (commit) begin
            lut <= shadow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out       <= lut[in];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FOP_HIT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (out_valid && out_ready && out && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + CW'(1);
        end
    end
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: doc/fop_lut_eval.md
FOP_LUT_EVAL -- requirements
Module: fop_lut_eval

Interface
REQ-001 SHALL have parameter N, default 4, meaning input vector width (1..8).
REQ-002 SHALL have parameter INIT, default 16'h29AF (sized 2**N bits), meaning reset truth table with bit k = f(k).
REQ-003 SHALL have parameter CW, default 8, meaning hit-counter width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operand valid.
REQ-007 SHALL have port in_ready  output  1  operand accepted when in_valid & in_ready.
REQ-008 SHALL have port in  input  N  operand vector.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out  output  1  f(in) for the accepted operand.
REQ-012 SHALL have port cfg_valid  input  1  one serial table bit present.
REQ-013 SHALL have port cfg_bit  input  1  table bit, index 2**N-1 first, index 0 last.
REQ-014 SHALL have port cfg_done  output  1  one-cycle pulse when a new table is committed.
REQ-015 SHALL have port hit_cnt  output  CW  count of accepted results with out=1 (see Configuration).

Function
REQ-016 SHALL evaluate out = table[in] and register it; latency 1 cycle from input acceptance to out_valid.
REQ-017 SHALL drive in_ready = !out_valid | out_ready (single output register, no bubble under continuous flow).
REQ-018 SHALL hold out and out_valid stable while out_valid & !out_ready.
REQ-019 SHALL clear out_valid on out_ready when no new operand is accepted in that cycle.
REQ-020 SHALL load the table through a loader FSM: IDLE -> SHIFT on first cfg_valid; SHIFT counts accepted bits; SHIFT -> COMMIT after bit 2**N accepted; COMMIT -> IDLE unconditionally.
REQ-021 SHALL shift bits into a shadow register; the active table is unchanged until COMMIT.
REQ-022 SHALL copy shadow to active table and pulse cfg_done in the COMMIT cycle; cfg_valid during COMMIT is ignored.
REQ-023 SHALL evaluate an operand accepted in the COMMIT cycle with the old table; the new table applies from the next cycle.
REQ-024 SHALL let cfg_valid gaps (cfg_valid=0) pause SHIFT without losing progress.
REQ-025 SHALL keep evaluation fully operational during IDLE, SHIFT and COMMIT.
REQ-026 SHALL increment hit_cnt when a result with out=1 is accepted (out_valid & out_ready), saturating at 2**CW-1, never wrapping.

Reset
REQ-027 SHALL on rst_n=0 set out_valid=0, out=0, cfg_done=0, hit_cnt=0, table=INIT, shadow=0, bit counter=0, FSM=IDLE.
REQ-028 SHALL discard a partially shifted table on reset mid-load; active table returns to INIT.
REQ-029 SHALL drive in_ready=1 while in reset-released idle with out_valid=0.

Configuration
REQ-030 SHALL use macro FOP_HIT_CNT_EN: defined -> hit counter per REQ-026; undefined -> counter logic absent, hit_cnt tied to 0.

Structure
REQ-031 SHALL place the loader state enum (IDLE, SHIFT, COMMIT) and the default 4-input table constant 16'h29AF in package fop_pkg.
REQ-032 SHALL implement the serial loader as sub-module fop_cfg_loader (outputs shadow table, commit strobe).

Verification
REQ-033 SHALL cover reset then in=0..15 back-to-back, out_ready=1 -> out=1 exactly for 0,1,2,3,5,7,8,11,13, one result per cycle.
REQ-034 SHALL cover in=5 accepted, out_ready=0 for 3 cycles -> out_valid=1, out=1 held, in_ready=0; next operand accepted the cycle out_ready rises.
REQ-035 SHALL cover serial load of 16'h0010 with cfg_valid gaps, in=4 in COMMIT cycle -> out=0; in=4 next cycle -> out=1; cfg_done single pulse.
REQ-036 SHALL cover rst_n low after 7 of 16 bits loaded -> in=4 afterwards gives out=0 (INIT), next full load starts from bit 15.
REQ-037 SHALL cover FOP_HIT_CNT_EN defined, CW=2, five in=0 results accepted -> hit_cnt=3 (saturated); undefined -> hit_cnt=0.
